// File: rtl/gb_top.sv
// gb_top: Ghostbus register/RAM endpoint.
// Decodes a 24-bit word address onto a handful of small control registers
// and 8x8 RAMs. Reads are pipelined uniformly to a 3-cycle latency.
module gb_top #(
  parameter int FOO_COPIES = 4,
  parameter int TOP_BAZ    = 1
) (
  input  logic        gb_clk,
  input  logic        gb_rst,
  input  logic [23:0] gb_addr,
  input  logic [31:0] gb_wdata,
  input  logic        gb_wen,
  input  logic        gb_rstb,
  output logic [31:0] gb_rdata
);

  // Copy count as a 3-bit value so it compares cleanly against a 2-bit index.
  localparam logic [2:0] FOO_N   = 3'(FOO_COPIES);
  localparam bit         HAS_BAZ = (TOP_BAZ != 0);

  // Control registers. Foo copies at or above FOO_N are never written and
  // therefore stay at their reset value of zero.
  logic [7:0] top_reg;
  logic [3:0] top_baz;
  logic [3:0] top_foo [4];

  // RAMs have no reset; their zero contents come from device configuration.
  logic [7:0] baz_ram [8];
  logic [7:0] foo_ram [4][8];

  // Address decode: full 24-bit compares so nothing aliases.
  logic hit_top;
  logic hit_baz;
  logic hit_foo_reg;
  logic hit_baz_ram;
  logic hit_foo_ram;
  logic wr_ok;

  assign hit_top     = (gb_addr == 24'h00_0000);
  assign hit_baz     = HAS_BAZ && (gb_addr == 24'h00_0001);
  assign hit_foo_reg = (gb_addr[23:2] == 22'h1) && ({1'b0, gb_addr[1:0]} < FOO_N);
  assign hit_baz_ram = (gb_addr[23:3] == 21'h1);
  assign hit_foo_ram = (gb_addr[23:5] == 19'h1) && ({1'b0, gb_addr[4:3]} < FOO_N);
  assign wr_ok       = gb_wen && !gb_rst;

  // Only the low byte of write data ever reaches storage.
  logic unused_wdata;
  assign unused_wdata = ^gb_wdata[31:8];

  // Register writes, truncated to each register's width.
  always_ff @(posedge gb_clk or posedge gb_rst) begin
    if (gb_rst) begin
      top_reg <= '0;
      top_baz <= '0;
      for (int n = 0; n < 4; n++) top_foo[n] <= '0;
    end else if (gb_wen) begin
      if (hit_top)     top_reg                 <= gb_wdata[7:0];
      if (hit_baz)     top_baz                 <= gb_wdata[3:0];
      if (hit_foo_reg) top_foo[gb_addr[1:0]]   <= gb_wdata[3:0];
    end
  end

  // RAM writes; contents survive reset, but writes are blocked while it is held.
  always_ff @(posedge gb_clk) begin
    if (wr_ok && hit_baz_ram) baz_ram[gb_addr[2:0]]               <= gb_wdata[7:0];
    if (wr_ok && hit_foo_ram) foo_ram[gb_addr[4:3]][gb_addr[2:0]] <= gb_wdata[7:0];
  end

  // Read mux sees storage before the current edge, so a same-cycle
  // write and read to one address returns the old value.
  logic [31:0] rd_mux;
  always_comb begin
    rd_mux = '0;
    if (hit_top)          rd_mux = {24'd0, top_reg};
    else if (hit_baz)     rd_mux = {28'd0, top_baz};
    else if (hit_foo_reg) rd_mux = {28'd0, top_foo[gb_addr[1:0]]};
    else if (hit_baz_ram) rd_mux = {24'd0, baz_ram[gb_addr[2:0]]};
    else if (hit_foo_ram) rd_mux = {24'd0, foo_ram[gb_addr[4:3]][gb_addr[2:0]]};
  end

  // Three-stage read pipeline: capture on edge R, move through two more
  // stages, and land in gb_rdata on edge R+3 where it is held until the
  // next read's data arrives. Reset flushes every stage.
  logic        s1_valid, s2_valid, s3_valid;
  logic [31:0] s1_data,  s2_data,  s3_data;

  always_ff @(posedge gb_clk or posedge gb_rst) begin
    if (gb_rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
      s1_data  <= '0;
      s2_data  <= '0;
      s3_data  <= '0;
      gb_rdata <= '0;
    end else begin
      s1_valid <= gb_rstb;
      s1_data  <= rd_mux;
      s2_valid <= s1_valid;
      s2_data  <= s1_data;
      s3_valid <= s2_valid;
      s3_data  <= s2_data;
      if (s3_valid) gb_rdata <= s3_data;
    end
  end

endmodule

// File: tb/tb_gb_top.sv
// tb_gb_top: directed, table-driven checks of gb_top.
// dut_a uses the default parameters; dut_b uses FOO_COPIES=2, TOP_BAZ=0.
// Both share the same bus inputs so every write and read hits both.
module tb_gb_top;

  logic        gb_clk;
  logic        gb_rst;
  logic [23:0] gb_addr;
  logic [31:0] gb_wdata;
  logic        gb_wen;
  logic        gb_rstb;
  logic [31:0] rdata_a;
  logic [31:0] rdata_b;

  int checks = 0;
  int errors = 0;

  gb_top dut_a (
    .gb_clk   (gb_clk),
    .gb_rst   (gb_rst),
    .gb_addr  (gb_addr),
    .gb_wdata (gb_wdata),
    .gb_wen   (gb_wen),
    .gb_rstb  (gb_rstb),
    .gb_rdata (rdata_a)
  );

  gb_top #(.FOO_COPIES(2), .TOP_BAZ(0)) dut_b (
    .gb_clk   (gb_clk),
    .gb_rst   (gb_rst),
    .gb_addr  (gb_addr),
    .gb_wdata (gb_wdata),
    .gb_wen   (gb_wen),
    .gb_rstb  (gb_rstb),
    .gb_rdata (rdata_b)
  );

  // 10 ns bus clock.
  initial gb_clk = 1'b0;
  always #5 gb_clk = ~gb_clk;

  // Hard stop in case something wedges.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  vec_t vecs[$];
  logic [23:0] mapped[$];

  function automatic vec_t make_vec(logic [23:0] a, logic [31:0] w, logic [31:0] ea, logic [31:0] eb);
    vec_t v;
    v.addr  = a;
    v.wdata = w;
    v.exp_a = ea;
    v.exp_b = eb;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [23:0] a,
                             input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s addr=0x%0h actual=0x%0h required=0x%0h", name, a, actual, expected);
    end
  endtask

  // One write strobe, driven between clock edges.
  task automatic write_word(input logic [23:0] a, input logic [31:0] d);
    @(negedge gb_clk);
    gb_addr  = a;
    gb_wdata = d;
    gb_wen   = 1'b1;
    @(negedge gb_clk);
    gb_wen   = 1'b0;
  endtask

  // One read strobe; returns both DUTs' data sampled just after edge R+3.
  task automatic read_word(input logic [23:0] a, output logic [31:0] ra, output logic [31:0] rb);
    @(negedge gb_clk);
    gb_addr = a;
    gb_rstb = 1'b1;
    @(negedge gb_clk);
    gb_rstb = 1'b0;
    repeat (3) @(negedge gb_clk);
    ra = rdata_a;
    rb = rdata_b;
  endtask

  // Write every table entry, then read every entry back.
  task automatic applyStimulus(input string name, input bit do_write);
    logic [31:0] ra, rb;
    if (do_write)
      foreach (vecs[i]) write_word(vecs[i].addr, vecs[i].wdata);
    foreach (vecs[i]) begin
      read_word(vecs[i].addr, ra, rb);
      checkOutput({name, "_a"}, vecs[i].addr, ra, vecs[i].exp_a);
      checkOutput({name, "_b"}, vecs[i].addr, rb, vecs[i].exp_b);
    end
  endtask

  initial begin
    logic [31:0] ra, rb, ra2, rb2;
    logic [7:0]  base;

    gb_rst   = 1'b1;
    gb_addr  = '0;
    gb_wdata = '0;
    gb_wen   = 1'b0;
    gb_rstb  = 1'b0;

    // Mapped address list and write/readback table.
    mapped.push_back(24'h00);
    mapped.push_back(24'h01);
    for (int a = 24'h04; a <= 24'h0F; a++) mapped.push_back(24'(a));
    for (int a = 24'h20; a <= 24'h3F; a++) mapped.push_back(24'(a));

    vecs.push_back(make_vec(24'h00, 32'hCC, 32'hCC, 32'hCC));
    vecs.push_back(make_vec(24'h01, 32'h01, 32'h01, 32'h00));
    for (int n = 0; n < 4; n++)
      vecs.push_back(make_vec(24'(4 + n), 32'(4 + n), 32'(4 + n), (n < 2) ? 32'(4 + n) : 32'h0));
    for (int i = 0; i < 8; i++)
      vecs.push_back(make_vec(24'(8 + i), 32'(8'hE8 + i), 32'(8'hE8 + i), 32'(8'hE8 + i)));
    for (int n = 0; n < 4; n++) begin
      case (n)
        0:       base = 8'hD0;
        1:       base = 8'hC8;
        2:       base = 8'hB0;
        default: base = 8'hA8;
      endcase
      for (int i = 0; i < 8; i++)
        vecs.push_back(make_vec(24'(32 + 8 * n + i), 32'(base + 8'(i)), 32'(base + 8'(i)),
                                (n < 2) ? 32'(base + 8'(i)) : 32'h0));
    end

    repeat (2) @(negedge gb_clk);
    checkOutput("reset_rdata_a", 24'h0, rdata_a, 32'h0);
    checkOutput("reset_rdata_b", 24'h0, rdata_b, 32'h0);
    gb_rst = 1'b0;

    // Post-reset: every mapped address reads the same twice; registers are 0.
    foreach (mapped[i]) begin
      read_word(mapped[i], ra, rb);
      read_word(mapped[i], ra2, rb2);
      checkOutput("repeat_a", mapped[i], ra2, ra);
      checkOutput("repeat_b", mapped[i], rb2, rb);
      if (mapped[i] < 24'h08) begin
        checkOutput("reset_reg_a", mapped[i], ra, 32'h0);
        checkOutput("reset_reg_b", mapped[i], rb, 32'h0);
      end
    end

    $display("[TB] write/readback table");
    applyStimulus("readback", 1'b1);

    $display("[TB] width truncation");
    write_word(24'h00, 32'hFFFF_FFFF);
    write_word(24'h04, 32'hFFFF_FFFF);
    write_word(24'h08, 32'hFFFF_FFFF);
    read_word(24'h00, ra, rb);
    checkOutput("trunc_top_a", 24'h00, ra, 32'hFF);
    checkOutput("trunc_top_b", 24'h00, rb, 32'hFF);
    read_word(24'h04, ra, rb);
    checkOutput("trunc_foo_a", 24'h04, ra, 32'hF);
    checkOutput("trunc_foo_b", 24'h04, rb, 32'hF);
    read_word(24'h08, ra, rb);
    checkOutput("trunc_ram_a", 24'h08, ra, 32'hFF);
    checkOutput("trunc_ram_b", 24'h08, rb, 32'hFF);
    write_word(24'h00, 32'hCC);
    write_word(24'h04, 32'h04);
    write_word(24'h08, 32'hE8);

    $display("[TB] unmapped addresses");
    write_word(24'h02, 32'h12);
    write_word(24'h10, 32'h12);
    write_word(24'h40, 32'h12);
    write_word(24'h100, 32'h12);
    write_word(24'h800000, 32'h12);
    read_word(24'h02, ra, rb);
    checkOutput("unmap_02_a", 24'h02, ra, 32'h0);
    read_word(24'h10, ra, rb);
    checkOutput("unmap_10_a", 24'h10, ra, 32'h0);
    read_word(24'h40, ra, rb);
    checkOutput("unmap_40_a", 24'h40, ra, 32'h0);
    checkOutput("unmap_40_b", 24'h40, rb, 32'h0);
    read_word(24'h100, ra, rb);
    checkOutput("alias_100_a", 24'h100, ra, 32'h0);
    read_word(24'h800000, ra, rb);
    checkOutput("alias_hi_a", 24'h800000, ra, 32'h0);
    applyStimulus("after_unmap", 1'b0);

    $display("[TB] same-cycle write and read");
    @(negedge gb_clk);
    gb_addr  = 24'h09;
    gb_wdata = 32'h55;
    gb_wen   = 1'b1;
    gb_rstb  = 1'b1;
    @(negedge gb_clk);
    gb_wen   = 1'b0;
    gb_rstb  = 1'b0;
    repeat (3) @(negedge gb_clk);
    checkOutput("wr_rd_old_a", 24'h09, rdata_a, 32'hE9);
    checkOutput("wr_rd_old_b", 24'h09, rdata_b, 32'hE9);
    read_word(24'h09, ra, rb);
    checkOutput("wr_rd_new_a", 24'h09, ra, 32'h55);
    write_word(24'h09, 32'hE9);

    $display("[TB] back-to-back reads");
    @(negedge gb_clk);
    gb_addr = 24'h00;
    gb_rstb = 1'b1;
    @(negedge gb_clk);
    gb_addr = 24'h04;
    @(negedge gb_clk);
    gb_addr = 24'h08;
    @(negedge gb_clk);
    gb_rstb = 1'b0;
    @(negedge gb_clk);
    checkOutput("b2b_0_a", 24'h00, rdata_a, 32'hCC);
    @(negedge gb_clk);
    checkOutput("b2b_1_a", 24'h04, rdata_a, 32'h04);
    @(negedge gb_clk);
    checkOutput("b2b_2_a", 24'h08, rdata_a, 32'hE8);
    checkOutput("b2b_2_b", 24'h08, rdata_b, 32'hE8);

    $display("[TB] exact latency");
    @(negedge gb_clk);
    gb_addr = 24'h00;
    gb_rstb = 1'b1;
    @(negedge gb_clk);
    gb_rstb = 1'b0;
    checkOutput("lat_r0_a", 24'h00, rdata_a, 32'hE8);
    @(negedge gb_clk);
    checkOutput("lat_r1_a", 24'h00, rdata_a, 32'hE8);
    @(negedge gb_clk);
    checkOutput("lat_r2_a", 24'h00, rdata_a, 32'hE8);
    @(negedge gb_clk);
    checkOutput("lat_r3_a", 24'h00, rdata_a, 32'hCC);

    $display("[TB] reset mid-read");
    @(negedge gb_clk);
    gb_addr = 24'h08;
    gb_rstb = 1'b1;
    @(negedge gb_clk);
    gb_rstb = 1'b0;
    @(negedge gb_clk);
    gb_rst   = 1'b1;
    gb_addr  = 24'h0A;
    gb_wdata = 32'h99;
    gb_wen   = 1'b1;
    #1;
    checkOutput("rst_async_a", 24'h08, rdata_a, 32'h0);
    checkOutput("rst_async_b", 24'h08, rdata_b, 32'h0);
    @(negedge gb_clk);
    gb_wen = 1'b0;
    gb_rst = 1'b0;
    repeat (5) @(negedge gb_clk);
    checkOutput("rst_no_stale_a", 24'h08, rdata_a, 32'h0);
    checkOutput("rst_no_stale_b", 24'h08, rdata_b, 32'h0);
    read_word(24'h00, ra, rb);
    checkOutput("rst_top_a", 24'h00, ra, 32'h0);
    checkOutput("rst_top_b", 24'h00, rb, 32'h0);
    read_word(24'h04, ra, rb);
    checkOutput("rst_foo_a", 24'h04, ra, 32'h0);
    read_word(24'h08, ra, rb);
    checkOutput("rst_ram_a", 24'h08, ra, 32'hE8);
    checkOutput("rst_ram_b", 24'h08, rb, 32'hE8);
    read_word(24'h0A, ra, rb);
    checkOutput("rst_blocks_wr_a", 24'h0A, ra, 32'hEA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gb_top.md
# gb_top

Register/RAM endpoint for the Ghostbus demonstration design (RTL module `top`). It decodes a 24-bit local-bus address to a set of control registers and small dual-port RAMs: one top register, an optional baz register, `FOO_COPIES` replicated foo blocks (each one 4-bit register and one 8×8 RAM), and one baz RAM. Every location is read/write over the `gb_*` bus. Reads return the stored value zero-extended to 32 bits.

## Interface
- `FOO_COPIES`, default 4: number of foo instances; legal values are 1..4.
- `TOP_BAZ`, default 1: 1 instantiates the `top_baz` register; 0 omits it.
- `gb_clk`  in  1  bus clock; all state is on its rising edge.
- `gb_rst`  in  1  asynchronous, active-high reset.
- `gb_addr`  in  24  word address.
- `gb_wdata`  in  32  write data.
- `gb_wen`  in  1  write strobe, one cycle per write.
- `gb_rstb`  in  1  read strobe, one cycle per read.
- `gb_rdata`  out  32  read data.

## Operation
Memory map; unused upper data bits read as 0:
- 0x00: `top_reg`, 8-bit.
- 0x01: `top_baz`, 4-bit; present only when `TOP_BAZ`=1.
- 0x04+n: `top_foo_n[n]`, 4-bit, for n=0..3.
- 0x08–0x0F: `baz_ram`, 8 entries × 8-bit.
- 0x20+8n .. 0x27+8n: `foo_ram[n]`, 8 entries × 8-bit, for n=0..3.

Write behaviour:
- A write (`gb_wen`=1) stores `gb_wdata` truncated to the target width.
- Writes to unmapped addresses are ignored.
- Writes to foo copies n ≥ `FOO_COPIES` are ignored.
- Writes to 0x01 are ignored when `TOP_BAZ`=0.

Read behaviour:
- A read (`gb_rstb`=1) returns the zero-extended value.
- Unmapped addresses, absent foo copies and absent `top_baz` read 0.
- Reads have no side effects and are repeatable.

Reset:
- `gb_rst` clears `top_reg`, `top_baz`, all `top_foo_n` and `gb_rdata` to 0 immediately (asynchronous).
- RAM contents are not affected by reset. RAMs power up as zero (initialised at configuration).

Address decode: full 24-bit compare. Aliasing is forbidden, e.g. 0x100 is unmapped.

## Timing
- Write: `gb_addr`, `gb_wdata` and `gb_wen` are sampled on edge W. The new value is visible to a read sampled on edge W+1 or later.
- Read latency is 3 cycles:
  - `gb_addr` and `gb_rstb` are sampled on edge R.
  - `gb_rdata` is valid after edge R+3 and is held until the next read's data replaces it.
  - The bus master samples `gb_rdata` after R+3.
- Registers and RAMs share the same 3-cycle read latency, so the read path is pipelined uniformly.
- Back-to-back reads (one per cycle) are supported and return data in order.
- `gb_wen` and `gb_rstb` asserted in the same cycle on the same address: the write completes and the read returns the old value.
- Reset asserted mid-read: the read pipeline is flushed and `gb_rdata` becomes 0. No stale data appears after reset is released.
- Writes are not accepted while `gb_rst`=1.

## Test plan
- After reset, read all 46 mapped addresses twice → each pair matches. Registers read 0x0.
- Write each address, then read it back. Writes are: 0x00←0xCC, 0x01←0x01, 0x04..0x07←0x04..0x07, 0x08..0x0F←0xE8..0xEF, 0x20..0x27←0xD0..0xD7, 0x28..0x2F←0xC8..0xCF, 0x30..0x37←0xB0..0xB7, 0x38..0x3F←0xA8..0xAF → every read equals the written value.
- Width truncation: write 0xFFFFFFFF to 0x00, 0x04 and 0x08 → reads return 0xFF, 0xF and 0xFF respectively.
- Parameters `FOO_COPIES`=2, `TOP_BAZ`=0: write 0x5 to 0x06 and 0x01, and 0x77 to 0x30 → all three read 0. Copy 0 and copy 1 still work.
- Unmapped addresses: write 0x12 to 0x02, 0x10 and 0x40 → each reads 0; no mapped location changes.
- Latency and reset: a read of 0x00 holding 0xCC gives data after exactly 3 edges. Pulsing `gb_rst` then gives `gb_rdata`=0 and 0x00 reads 0, while 0x08 still reads 0xE8.
